intersection_ctrl: RTL

INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

---
 rtl/intersection_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/intersection_ctrl.sv
// rtl/intersection_ctrl.sv - two-phase intersection controller with all-red clearance and pedestrian walk
// Moore outputs decoded from state; phase timer restarts on every state change.
module intersection_ctrl #(
  parameter int GREEN_MIN = 8,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 6
) (
  input  logic clock,
  input  logic reset_n,
  input  logic Ped,
  input  logic CarNS,
  input  logic CarEW,
  output logic NS_G,
  output logic NS_Y,
  output logic NS_R,
  output logic EW_G,
  output logic EW_Y,
  output logic EW_R,
  output logic Walk
);

  localparam logic [2:0] ST_NSG  = 3'd0;
  localparam logic [2:0] ST_NSY  = 3'd1;
  localparam logic [2:0] ST_AR1  = 3'd2;
  localparam logic [2:0] ST_EWG  = 3'd3;
  localparam logic [2:0] ST_EWY  = 3'd4;
  localparam logic [2:0] ST_AR2  = 3'd5;
  localparam logic [2:0] ST_WALK = 3'd6;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  localparam logic [7:0] GREEN_LAST  = 8'(GREEN_MIN - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_T - 1);
  localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_T - 1);
  localparam logic [7:0] WALK_LAST   = 8'(WALK_T - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [7:0] timer;
  logic       ped_pend;
  logic       next_dir;
  logic       state_change;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_NSG:  if (timer >= GREEN_LAST && (CarEW || ped_pend)) state_nxt = ST_NSY;
      ST_NSY:  if (timer == YELLOW_LAST) state_nxt = ST_AR1;
      ST_AR1:  if (timer == ALLRED_LAST) state_nxt = ped_pend ? ST_WALK : ST_EWG;
      ST_EWG:  if (timer >= GREEN_LAST && (CarNS || ped_pend)) state_nxt = ST_EWY;
      ST_EWY:  if (timer == YELLOW_LAST) state_nxt = ST_AR2;
      ST_AR2:  if (timer == ALLRED_LAST) state_nxt = ped_pend ? ST_WALK : ST_NSG;
      ST_WALK: if (timer == WALK_LAST) state_nxt = (next_dir == DIR_EW) ? ST_EWG : ST_NSG;
      default: state_nxt = ST_NSG;
    endcase
  end

  assign state_change = (state_nxt != state);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_NSG;
      timer    <= 8'd0;
      ped_pend <= 1'b0;
      next_dir <= DIR_EW;
    end else begin
      state <= state_nxt;
      if (state_change)
        timer <= 8'd0;
      else if (timer != 8'hFF)
        timer <= timer + 8'd1;
      // A request arriving on the entry edge is not consumed by this walk
      if (Ped)
        ped_pend <= 1'b1;
      else if (state_change && state_nxt == ST_WALK)
        ped_pend <= 1'b0;
      if (state == ST_AR1 && state_change)
        next_dir <= DIR_EW;
      else if (state == ST_AR2 && state_change)
        next_dir <= DIR_NS;
    end
  end

  always_comb begin
    NS_G = 1'b0;
    NS_Y = 1'b0;
    NS_R = 1'b0;
    EW_G = 1'b0;
    EW_Y = 1'b0;
    EW_R = 1'b0;
    Walk = 1'b0;
    case (state)
      ST_NSG:  begin NS_G = 1'b1; EW_R = 1'b1; end
      ST_NSY:  begin NS_Y = 1'b1; EW_R = 1'b1; end
      ST_EWG:  begin EW_G = 1'b1; NS_R = 1'b1; end
      ST_EWY:  begin EW_Y = 1'b1; NS_R = 1'b1; end
      ST_WALK: begin NS_R = 1'b1; EW_R = 1'b1; Walk = 1'b1; end
      default: begin NS_R = 1'b1; EW_R = 1'b1; end
    endcase
  end

endmodule
